alu_dispatch: RTL and testbench

- Producer side of the existing 64-bit combinational ALU: accepts 32-bit RV64I integer instructions over a valid/ready handshake.
- Decodes each accepted instruction and reads operands from an internal 32x64 register file.
- Drives the ALU's rs1/rs2/func3/func7 inputs, captures the ALU result and writes it back.
- Sits between fetch and the ALU instance; the ALU is instantiated in the parent and wired to the alu_* ports.

---
 rtl/rv_alu_pkg.sv | 19 +
 rtl/rv_alu_decode.sv | 64 ++++++
 rtl/alu_dispatch.sv | 146 ++++++++++++++
 tb/tb_alu_dispatch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// rtl/rv_alu_pkg.sv - shared RV64I opcode, func3 and func7 constants
package rv_alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/rv_alu_decode.sv
// rtl/rv_alu_decode.sv - combinational decode of RV64I OP/OP-IMM instructions
module rv_alu_decode
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_func3,
  output logic [6:0]      o_func7,
  output logic [XLEN-1:0] o_imm,
  output logic            o_use_imm,
  output logic            o_legal
);

  logic [6:0] w_opcode;
  logic [6:0] w_f7;
  logic [5:0] w_imm_hi;

  assign w_opcode = i_instr[6:0];
  assign w_f7     = i_instr[31:25];
  assign w_imm_hi = i_instr[31:26];
  assign o_rd     = i_instr[11:7];
  assign o_func3  = i_instr[14:12];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];

  always_comb begin
    o_func7   = F7_BASE;
    o_use_imm = 1'b0;
    o_legal   = 1'b0;
    o_imm     = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    case (w_opcode)
      OPC_OP: begin
        o_func7 = w_f7;
        o_legal = (w_f7 == F7_BASE) ||
                  ((w_f7 == F7_ALT) && ((o_func3 == F3_ADD) || (o_func3 == F3_SR)));
      end
      OPC_OPIMM: begin
        o_use_imm = 1'b1;
        o_legal   = 1'b1;
        // shift immediates carry only the shamt; func7 already selects arithmetic vs logical
        if ((o_func3 == F3_SLL) || (o_func3 == F3_SR)) begin
          o_imm = {{(XLEN-6){1'b0}}, i_instr[25:20]};
        end
        if (o_func3 == F3_SLL) begin
          o_legal = (w_imm_hi == 6'b000000);
        end else if (o_func3 == F3_SR) begin
          if (w_imm_hi == 6'b010000) begin
            o_func7 = F7_ALT;
          end else begin
            o_legal = (w_imm_hi == 6'b000000);
          end
        end
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - instruction dispatcher feeding an external combinational ALU
module alu_dispatch
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic [XLEN-1:0]   alu_rs1,
  output logic [XLEN-1:0]   alu_rs2,
  output logic [2:0]        alu_func3,
  output logic [6:0]        alu_func7,
  input  logic [XLEN-1:0]   alu_rd,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              illegal,
  output logic [ICNT_W-1:0] illegal_cnt,
  output logic [63:0]       retire_cnt,
  input  logic [4:0]        dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata
);

  logic [XLEN-1:0]   r_regs [NREGS];
  logic              r_ready;
  logic              r_d_valid;
  logic              r_d_legal;
  logic [4:0]        r_d_rd;
  logic [XLEN-1:0]   r_d_op1;
  logic [XLEN-1:0]   r_d_op2;
  logic [2:0]        r_d_f3;
  logic [6:0]        r_d_f7;
  logic              r_wb_valid;
  logic [4:0]        r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_illegal;
  logic [ICNT_W-1:0] r_illegal_cnt;
  logic [63:0]       r_retire_cnt;

  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [XLEN-1:0]   w_imm;
  logic              w_use_imm;
  logic              w_legal;
  logic              w_accept;
  logic              w_retire;
  logic              w_fwd_ok;
  logic [XLEN-1:0]   w_src1;
  logic [XLEN-1:0]   w_src2;

  rv_alu_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (in_instr),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_func3   (w_f3),
    .o_func7   (w_f7),
    .o_imm     (w_imm),
    .o_use_imm (w_use_imm),
    .o_legal   (w_legal)
  );

  assign in_ready = r_ready && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_d_valid && !flush;

  // the instruction in D writes its result on the same edge a dependent one is accepted
  assign w_fwd_ok = r_d_valid && r_d_legal && (r_d_rd != 5'd0);
  assign w_src1 = (w_rs1 == 5'd0)                ? '0     :
                  (w_fwd_ok && (w_rs1 == r_d_rd)) ? alu_rd : r_regs[w_rs1];
  assign w_src2 = w_use_imm                       ? w_imm  :
                  (w_rs2 == 5'd0)                ? '0     :
                  (w_fwd_ok && (w_rs2 == r_d_rd)) ? alu_rd : r_regs[w_rs2];

  assign alu_rs1   = r_d_valid ? r_d_op1 : '0;
  assign alu_rs2   = r_d_valid ? r_d_op2 : '0;
  assign alu_func3 = r_d_valid ? r_d_f3  : '0;
  assign alu_func7 = r_d_valid ? r_d_f7  : '0;

  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_illegal_cnt;
  assign retire_cnt  = r_retire_cnt;
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? '0 : r_regs[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_ready       <= 1'b0;
      r_d_valid     <= 1'b0;
      r_d_legal     <= 1'b0;
      r_d_rd        <= '0;
      r_d_op1       <= '0;
      r_d_op2       <= '0;
      r_d_f3        <= '0;
      r_d_f7        <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
      r_retire_cnt  <= '0;
    end else begin
      r_ready    <= 1'b1;
      r_d_valid  <= w_accept;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      if (w_accept) begin
        r_d_legal <= w_legal;
        r_d_rd    <= w_rd;
        r_d_op1   <= w_src1;
        r_d_op2   <= w_src2;
        r_d_f3    <= w_f3;
        r_d_f7    <= w_f7;
      end
      if (w_retire) begin
        if (r_d_legal) begin
          if (r_d_rd != 5'd0) begin
            r_regs[r_d_rd] <= alu_rd;
          end
          r_wb_valid   <= 1'b1;
          r_wb_addr    <= r_d_rd;
          r_wb_data    <= alu_rd;
          r_retire_cnt <= r_retire_cnt + 64'd1;
        end else begin
          r_illegal     <= 1'b1;
          r_illegal_cnt <= r_illegal_cnt + ICNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch with a reference ALU and regfile model
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic [63:0] alu_rs1;
  logic [63:0] alu_rs2;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [63:0] alu_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        illegal;
  logic [31:0] illegal_cnt;
  logic [63:0] retire_cnt;
  logic [4:0]  dbg_raddr;
  logic [63:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_regs [32];
  logic [63:0] m_retire;
  logic [31:0] m_illegal;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .illegal_cnt(illegal_cnt), .retire_cnt(retire_cnt),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd1:    return a << b[5:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3:    return (a < b) ? 64'd1 : 64'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_rd = alu_fn(alu_rs1, alu_rs2, alu_func3, alu_func7);

  function automatic void ref_decode(input logic [31:0] ins, output logic legal,
                                     output logic [6:0] f7, output logic use_imm,
                                     output logic [63:0] immv);
    logic [2:0] f3;
    f3 = ins[14:12];
    legal = 1'b0; f7 = 7'h00; use_imm = 1'b0;
    immv = {{52{ins[31]}}, ins[31:20]};
    if (ins[6:0] == 7'h33) begin
      f7 = ins[31:25];
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (ins[6:0] == 7'h13) begin
      use_imm = 1'b1;
      legal = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) immv = {58'd0, ins[25:20]};
      if (f3 == 3'd1) legal = (ins[31:26] == 6'h00);
      if (f3 == 3'd5) begin
        if (ins[31:26] == 6'h10) f7 = 7'h20;
        else legal = (ins[31:26] == 6'h00);
      end
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [5:0]  hi;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7)); f3 = 3'($urandom);
    hi = ($urandom_range(0, 2) == 0) ? 6'h10 : ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
    case ($urandom_range(0, 5))
      0:       return {7'h00, rs2, rs1, f3, rd, 7'h33};
      1:       return {7'h20, rs2, rs1, f3, rd, 7'h33};
      2:       return {7'($urandom), rs2, rs1, f3, rd, 7'h33};
      3:       return {12'($urandom), rs1, f3, rd, 7'h13};
      4:       return {hi, 6'($urandom), rs1, ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, rd, 7'h13};
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_instr = '0; dbg_raddr = 5'd5;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    m_retire = '0; m_illegal = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    checks++; if (retire_cnt !== 64'd0 || illegal_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", retire_cnt, illegal_cnt); end
    checks++; if (wb_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b/%b exp 0/0", wb_valid, illegal); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_first got %b exp 0", in_ready); end
    checks++; if (dbg_rdata !== 64'd0) begin errors++; $display("FAIL rst_dbg_x5 got %h exp 0", dbg_rdata); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_addi_neg();
    issue_one(32'hFFF00093);
    checks++; if (alu_rs1 !== 64'd0 || alu_rs2 !== '1) begin errors++; $display("FAIL addi_ops got %h/%h exp 0/ffffffffffffffff", alu_rs1, alu_rs2); end
    checks++; if (alu_func7 !== 7'h00 || alu_func3 !== 3'd0) begin errors++; $display("FAIL addi_func got %h/%h exp 0/0", alu_func7, alu_func3); end
    step();
    ref_regs[1] = '1; m_retire++;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== '1) begin errors++; $display("FAIL addi_wb got %b/%0d/%h exp 1/1/ffffffffffffffff", wb_valid, wb_addr, wb_data); end
    checks++; if (retire_cnt !== m_retire) begin errors++; $display("FAIL addi_retire got %0d exp %0d", retire_cnt, m_retire); end
    step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL addi_wb_pulse got %b exp 0", wb_valid); end
  endtask

  task automatic test_forward();
    in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    in_instr = 32'h00108133;
    step();
    in_valid = 1'b0;
    ref_regs[1] = 64'd5; m_retire++;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 64'd5) begin errors++; $display("FAIL fwd_wb_x1 got %b/%0d/%h exp 1/1/5", wb_valid, wb_addr, wb_data); end
    checks++; if (alu_rs1 !== 64'd5 || alu_rs2 !== 64'd5) begin errors++; $display("FAIL fwd_ops got %h/%h exp 5/5", alu_rs1, alu_rs2); end
    step();
    ref_regs[2] = 64'd10; m_retire++;
    dbg_raddr = 5'd2;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 64'd10) begin errors++; $display("FAIL fwd_wb_x2 got %b/%0d/%h exp 1/2/10", wb_valid, wb_addr, wb_data); end
    checks++; if (dbg_rdata !== 64'd10) begin errors++; $display("FAIL fwd_dbg_x2 got %h exp 10", dbg_rdata); end
  endtask

  task automatic test_shift_imm();
    issue_one(32'hFFF00093);
    step();
    ref_regs[1] = '1; m_retire++;
    issue_one(32'h43F0D193);
    checks++; if (alu_func7 !== 7'h20 || alu_rs2 !== 64'd63 || alu_rs1 !== '1) begin errors++; $display("FAIL srai_ops got f7=%h rs2=%h rs1=%h exp 20/3f/all-ones", alu_func7, alu_rs2, alu_rs1); end
    step();
    ref_regs[3] = '1; m_retire++;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== '1) begin errors++; $display("FAIL srai_wb got %b/%0d/%h exp 1/3/all-ones", wb_valid, wb_addr, wb_data); end
    issue_one(32'h40109213);
    step();
    m_illegal++;
    dbg_raddr = 5'd4;
    #1;
    checks++; if (illegal !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL slli_bad got ill=%b wb=%b exp 1/0", illegal, wb_valid); end
    checks++; if (illegal_cnt !== m_illegal || dbg_rdata !== 64'd0) begin errors++; $display("FAIL slli_bad_state got cnt=%0d x4=%h exp %0d/0", illegal_cnt, dbg_rdata, m_illegal); end
  endtask

  task automatic test_illegal_opcode();
    issue_one(32'h0000007F);
    step();
    m_illegal++;
    dbg_raddr = 5'd1;
    #1;
    checks++; if (illegal !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL opc_ill got ill=%b wb=%b exp 1/0", illegal, wb_valid); end
    checks++; if (illegal_cnt !== m_illegal || retire_cnt !== m_retire) begin errors++; $display("FAIL opc_cnt got %0d/%0d exp %0d/%0d", illegal_cnt, retire_cnt, m_illegal, m_retire); end
    checks++; if (dbg_rdata !== ref_regs[1]) begin errors++; $display("FAIL opc_regs got %h exp %h", dbg_rdata, ref_regs[1]); end
    step();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL opc_pulse got %b exp 0", illegal); end
  endtask

  task automatic test_x0_and_flush();
    issue_one(32'h00700013);
    step();
    m_retire++;
    dbg_raddr = 5'd0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd0 || wb_data !== 64'd7) begin errors++; $display("FAIL x0_wb got %b/%0d/%h exp 1/0/7", wb_valid, wb_addr, wb_data); end
    checks++; if (dbg_rdata !== 64'd0) begin errors++; $display("FAIL x0_dbg got %h exp 0", dbg_rdata); end
    issue_one(32'h00700013);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0;
    checks++; if (wb_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL flush_pulses got %b/%b exp 0/0", wb_valid, illegal); end
    checks++; if (retire_cnt !== m_retire || illegal_cnt !== m_illegal) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp %0d/%0d", retire_cnt, illegal_cnt, m_retire, m_illegal); end
    checks++; if (alu_rs2 !== 64'd0) begin errors++; $display("FAIL flush_dclr got %h exp 0", alu_rs2); end
  endtask

  task automatic test_random_back_to_back();
    logic        have_p, nv, nf, lg, ui;
    logic [31:0] p_instr, ni;
    logic [6:0]  f7;
    logic [63:0] immv, op1, op2, res;
    logic [4:0]  dr;
    have_p = 1'b0; p_instr = '0;
    for (int i = 0; i < 400; i++) begin
      if (have_p) begin
        ref_decode(p_instr, lg, f7, ui, immv);
        op1 = ref_regs[p_instr[19:15]];
        op2 = ui ? immv : ref_regs[p_instr[24:20]];
        if (lg) begin
          checks++; if (alu_rs1 !== op1 || alu_rs2 !== op2 || alu_func3 !== p_instr[14:12] || alu_func7 !== f7) begin
            errors++; $display("FAIL rnd_ops i=%0d got %h/%h/%h/%h exp %h/%h/%h/%h", i, alu_rs1, alu_rs2, alu_func3, alu_func7, op1, op2, p_instr[14:12], f7); end
        end
      end else begin
        checks++; if (alu_rs1 !== 64'd0 || alu_rs2 !== 64'd0) begin errors++; $display("FAIL rnd_idle_ops i=%0d got %h/%h exp 0/0", i, alu_rs1, alu_rs2); end
      end
      nf = (i < 396) && ($urandom_range(0, 9) == 0);
      nv = (i < 396) && ($urandom_range(0, 3) != 0);
      ni = rand_instr();
      flush = nf; in_valid = nv; in_instr = ni;
      dr = 5'($urandom_range(0, 7)); dbg_raddr = dr;
      #1;
      checks++; if (in_ready !== !nf || dbg_rdata !== ref_regs[dr]) begin
        errors++; $display("FAIL rnd_ready_dbg i=%0d got %b/%h exp %b/%h", i, in_ready, dbg_rdata, !nf, ref_regs[dr]); end
      step();
      if (have_p && !nf) begin
        ref_decode(p_instr, lg, f7, ui, immv);
        op1 = ref_regs[p_instr[19:15]];
        op2 = ui ? immv : ref_regs[p_instr[24:20]];
        res = alu_fn(op1, op2, p_instr[14:12], f7);
        if (lg) begin
          if (p_instr[11:7] != 5'd0) ref_regs[p_instr[11:7]] = res;
          m_retire++;
          checks++; if (wb_valid !== 1'b1 || illegal !== 1'b0 || wb_addr !== p_instr[11:7] || wb_data !== res) begin
            errors++; $display("FAIL rnd_wb i=%0d got %b/%b/%0d/%h exp 1/0/%0d/%h", i, wb_valid, illegal, wb_addr, wb_data, p_instr[11:7], res); end
        end else begin
          m_illegal++;
          checks++; if (wb_valid !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL rnd_ill i=%0d got %b/%b exp 0/1", i, wb_valid, illegal); end
        end
      end else begin
        checks++; if (wb_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rnd_quiet i=%0d got %b/%b exp 0/0", i, wb_valid, illegal); end
      end
      checks++; if (retire_cnt !== m_retire || illegal_cnt !== m_illegal) begin
        errors++; $display("FAIL rnd_cnt i=%0d got %0d/%0d exp %0d/%0d", i, retire_cnt, illegal_cnt, m_retire, m_illegal); end
      have_p = nv && !nf;
      p_instr = ni;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    issue_one(32'h00900393);
    dbg_raddr = 5'd1;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || retire_cnt !== 64'd0 || in_ready !== 1'b0 || dbg_rdata !== 64'd0) begin
      errors++; $display("FAIL midrst got wb=%b ret=%0d rdy=%b x1=%h exp 0/0/0/0", wb_valid, retire_cnt, in_ready, dbg_rdata); end
    step();
    rst_n = 1'b1;
    step(); step();
    dbg_raddr = 5'd7;
    #1;
    checks++; if (wb_valid !== 1'b0 || retire_cnt !== 64'd0 || dbg_rdata !== 64'd0) begin
      errors++; $display("FAIL midrst_drop got wb=%b ret=%0d x7=%h exp 0/0/0", wb_valid, retire_cnt, dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_addi_neg();
    test_forward();
    test_shift_imm();
    test_illegal_opcode();
    test_x0_and_flush();
    test_random_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
